// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage: EX->MEM pipeline register with valid/ready handshake on both sides.
// Define EX_MEM_SKID_EN for a two-entry skid buffer with a registered in_ready.
module ex_mem_pipe_stage #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_aluA,
  input  logic [DATA_W-1:0] in_aluB,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [ADDR_W-1:0] in_rs1_addr,
  input  logic [ADDR_W-1:0] in_rs2_addr,
  input  logic [CTRL_W-1:0] in_alu_ctrl,
  input  logic              in_reg_wb,
  input  logic              in_mem_we,
  input  logic              in_mem_re,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_aluA,
  output logic [DATA_W-1:0] out_aluB,
  output logic [DATA_W-1:0] out_store_data,
  output logic [ADDR_W-1:0] out_rs1_addr,
  output logic [ADDR_W-1:0] out_rs2_addr,
  output logic [CTRL_W-1:0] out_alu_ctrl,
  output logic              out_reg_wb,
  output logic              out_mem_we,
  output logic              out_mem_re,
  output logic [1:0]        occupancy
);
  localparam int PW = 3*DATA_W + 2*ADDR_W + CTRL_W + 3;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_n;
  logic [PW-1:0] in_pl, head;
  logic [2:0] head_ctl;
  logic in_xfer, out_xfer, load_head;
`ifdef EX_MEM_SKID_EN
  logic [PW-1:0] skid;
  logic load_skid, pop_skid;
`endif
  assign in_pl = {in_aluA, in_aluB, in_store_data, in_rs1_addr, in_rs2_addr, in_alu_ctrl,
                  in_reg_wb, in_mem_we, in_mem_re};
  assign in_xfer = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign out_valid = state != EMPTY;
  assign occupancy = state;
  // Data fields keep their last value in a bubble; only the control bits are squashed.
  assign {out_aluA, out_aluB, out_store_data, out_rs1_addr, out_rs2_addr, out_alu_ctrl, head_ctl} = head;
  assign {out_reg_wb, out_mem_we, out_mem_re} = head_ctl & {3{out_valid}};
  always_comb begin
    state_n = state;
    load_head = 1'b0;
`ifdef EX_MEM_SKID_EN
    load_skid = 1'b0;
    pop_skid = 1'b0;
`endif
    case (state)
      EMPTY: if (in_xfer) begin
        state_n = ONE;
        load_head = 1'b1;
      end
      ONE: if (in_xfer && out_xfer) load_head = 1'b1;
        else if (out_xfer) state_n = EMPTY;
`ifdef EX_MEM_SKID_EN
        else if (in_xfer) begin
          state_n = TWO;
          load_skid = 1'b1;
        end
      TWO: if (out_xfer) begin
        state_n = ONE;
        pop_skid = 1'b1;
      end
`endif
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n = EMPTY;
      load_head = 1'b0;
`ifdef EX_MEM_SKID_EN
      load_skid = 1'b0;
      pop_skid = 1'b0;
`endif
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) head <= '0;
    else if (load_head) head <= in_pl;
`ifdef EX_MEM_SKID_EN
    else if (pop_skid) head <= skid;
`endif
  end
`ifdef EX_MEM_SKID_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) skid <= '0;
    else if (load_skid) skid <= in_pl;
  end
  // Registered ready keeps out_ready off the combinational path to in_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) in_ready <= 1'b1;
    else in_ready <= state_n != TWO;
  end
`else
  assign in_ready = ~out_valid | out_ready;
`endif
endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// tb_ex_mem_pipe_stage: random and directed stimulus against a queue-based reference model.
module tb_ex_mem_pipe_stage;
  localparam int DW = 10;
  localparam int AW = 3;
  localparam int CW = 3;
  localparam int PW = 3*DW + 2*AW + CW + 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [DW-1:0] in_aluA = '0, in_aluB = '0, in_store_data = '0;
  logic [AW-1:0] in_rs1_addr = '0, in_rs2_addr = '0;
  logic [CW-1:0] in_alu_ctrl = '0;
  logic in_reg_wb = 1'b0, in_mem_we = 1'b0, in_mem_re = 1'b0;
  logic [DW-1:0] out_aluA, out_aluB, out_store_data;
  logic [AW-1:0] out_rs1_addr, out_rs2_addr;
  logic [CW-1:0] out_alu_ctrl;
  logic out_reg_wb, out_mem_we, out_mem_re;
  logic [1:0] occupancy;
  logic w_in_valid = 1'b0, w_out_ready = 1'b0, w_in_ready, w_out_valid;
  logic [15:0] w_in_aluA = '0, w_in_store_data = '0;
  logic [3:0] w_in_rs1_addr = '0, w_in_rs2_addr = '0;
  logic [15:0] w_out_aluA, w_out_aluB, w_out_store_data;
  logic [3:0] w_out_rs1_addr, w_out_rs2_addr;
  logic [2:0] w_out_alu_ctrl;
  logic w_out_reg_wb, w_out_mem_we, w_out_mem_re;
  logic [1:0] w_occupancy;
  int n_chk = 0, n_fail = 0;
  logic [PW-1:0] q[$];
  logic [PW-1:0] last = '0;
  logic got;
  always #5 clk = ~clk;
  ex_mem_pipe_stage #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluA(in_aluA), .in_aluB(in_aluB), .in_store_data(in_store_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_alu_ctrl(in_alu_ctrl),
    .in_reg_wb(in_reg_wb), .in_mem_we(in_mem_we), .in_mem_re(in_mem_re),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluA(out_aluA), .out_aluB(out_aluB), .out_store_data(out_store_data),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_alu_ctrl(out_alu_ctrl),
    .out_reg_wb(out_reg_wb), .out_mem_we(out_mem_we), .out_mem_re(out_mem_re),
    .occupancy(occupancy)
  );
  ex_mem_pipe_stage #(.DATA_W(16), .ADDR_W(4), .CTRL_W(3)) u_wide (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_aluA(w_in_aluA), .in_aluB(16'h0), .in_store_data(w_in_store_data),
    .in_rs1_addr(w_in_rs1_addr), .in_rs2_addr(w_in_rs2_addr), .in_alu_ctrl(3'd0),
    .in_reg_wb(1'b1), .in_mem_we(1'b0), .in_mem_re(1'b0),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_aluA(w_out_aluA), .out_aluB(w_out_aluB), .out_store_data(w_out_store_data),
    .out_rs1_addr(w_out_rs1_addr), .out_rs2_addr(w_out_rs2_addr), .out_alu_ctrl(w_out_alu_ctrl),
    .out_reg_wb(w_out_reg_wb), .out_mem_we(w_out_mem_we), .out_mem_re(w_out_mem_re),
    .occupancy(w_occupancy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [PW-1:0] pl_in();
    return {in_aluA, in_aluB, in_store_data, in_rs1_addr, in_rs2_addr, in_alu_ctrl,
            in_reg_wb, in_mem_we, in_mem_re};
  endfunction
  function automatic logic [PW-1:0] pl_out();
    return {out_aluA, out_aluB, out_store_data, out_rs1_addr, out_rs2_addr, out_alu_ctrl,
            out_reg_wb, out_mem_we, out_mem_re};
  endfunction
  function automatic logic exp_rdy();
`ifdef EX_MEM_SKID_EN
    return q.size() < 2;
`else
    return q.size() == 0 || out_ready;
`endif
  endfunction
  task automatic drive(input logic v, input logic r, input logic f, input logic [DW-1:0] a);
    in_valid = v;
    out_ready = r;
    flush = f;
    in_aluA = a;
    in_aluB = DW'($urandom);
    in_store_data = DW'($urandom);
    in_rs1_addr = AW'($urandom);
    in_rs2_addr = AW'($urandom);
    in_alu_ctrl = CW'($urandom);
    {in_reg_wb, in_mem_we, in_mem_re} = 3'($urandom);
  endtask
  task automatic check_out();
    logic [PW-1:0] e;
    e = q.size() > 0 ? q[0] : {last[PW-1:3], 3'b000};
    chk("payload", 64'(pl_out()), 64'(e));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
  endtask
  task automatic cycle();
    logic ix, ox;
    #1 chk("in_ready", 64'(in_ready), 64'(exp_rdy()));
    ix = in_valid && exp_rdy();
    ox = q.size() > 0 && out_ready;
    @(posedge clk);
    if (ox) void'(q.pop_front());
    if (flush) q.delete();
    else if (ix) q.push_back(pl_in());
    if (q.size() > 0) last = q[0];
    @(negedge clk);
    check_out();
  endtask
  task automatic check_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_payload", 64'(pl_out()), 64'd0);
  endtask
  initial begin
    #1 check_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, DW'(i));
      cycle();
      chk("stream_alu", 64'(out_aluA), 64'(i));
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    cycle();
    drive(1'b1, 1'b1, 1'b0, DW'(5));
    cycle();
    drive(1'b1, 1'b0, 1'b0, DW'(6));
    got = exp_rdy();
    cycle();
    chk("hold5", 64'(out_aluA), 64'd5);
    drive(!got, 1'b0, 1'b0, DW'(6));
    got = got | exp_rdy();
    cycle();
    chk("hold5b", 64'(out_aluA), 64'd5);
    drive(!got, 1'b1, 1'b0, DW'(6));
    cycle();
    chk("then6", 64'(out_aluA), 64'd6);
    drive(1'b0, 1'b1, 1'b0, '0);
    cycle();
    cycle();
    drive(1'b1, 1'b0, 1'b0, DW'($urandom));
    cycle();
    drive(1'b1, 1'b0, 1'b0, DW'($urandom));
    cycle();
    drive(1'b1, 1'b0, 1'b1, DW'($urandom));
    in_reg_wb = 1'b1;
    cycle();
    chk("flush_wb", 64'(out_reg_wb), 64'd0);
    for (int i = 0; i < 400; i++) begin
      drive($urandom % 4 != 0, $urandom % 5 < 3, $urandom % 20 == 0, DW'($urandom));
      cycle();
    end
    drive(1'b1, 1'b0, 1'b0, DW'($urandom));
    cycle();
    drive(1'b1, 1'b1, 1'b0, DW'($urandom));
    #3 reset = 1'b0;
    #1 check_reset();
    q.delete();
    last = '0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, DW'(10'h3FF));
    cycle();
    chk("alu_3ff", 64'(out_aluA), 64'h3FF);
    drive(1'b0, 1'b1, 1'b0, '0);
    cycle();
    w_in_valid = 1'b1;
    w_out_ready = 1'b1;
    w_in_store_data = 16'hBEEF;
    w_in_rs2_addr = 4'hA;
    w_in_aluA = 16'h1234;
    w_in_rs1_addr = 4'h5;
    @(posedge clk);
    @(negedge clk);
    w_in_valid = 1'b0;
    chk("w_valid", 64'(w_out_valid), 64'd1);
    chk("w_store", 64'(w_out_store_data), 64'hBEEF);
    chk("w_rs2", 64'(w_out_rs2_addr), 64'hA);
    chk("w_alu", 64'(w_out_aluA), 64'h1234);
    chk("w_rs1", 64'(w_out_rs1_addr), 64'h5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_mem_pipe_stage.md
EX_MEM_PIPE_STAGE -- requirements
Module: ex_mem_pipe_stage

Interface
REQ-001 Parameter DATA_W, default 10, width of ALU operands and store data.
REQ-002 Parameter ADDR_W, default 3, width of each register-file address field.
REQ-003 Parameter CTRL_W, default 3, width of ALU control.
REQ-004 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port flush  in  1  synchronous kill of all held entries.
REQ-007 Port in_valid  in  1; in_ready  out  1  EX-side handshake.
REQ-008 Port in_aluA, in_aluB, in_store_data  in  DATA_W each  operands and store data.
REQ-009 Port in_rs1_addr, in_rs2_addr  in  ADDR_W each  source/destination register addresses.
REQ-010 Port in_alu_ctrl  in  CTRL_W; in_reg_wb, in_mem_we, in_mem_re  in  1 each  control.
REQ-011 Port out_valid  out  1; out_ready  in  1  MEM-side handshake.
REQ-012 Port out_* (one per in_* field, same widths)  out  registered payload to MEM.
REQ-013 Port occupancy  out  2  number of held entries (0..2).

Function
REQ-014 A transfer SHALL occur on an edge where valid and ready are both high on that side.
REQ-015 Entry order SHALL be strictly FIFO; no entry is dropped or duplicated.
REQ-016 Latency SHALL be one cycle: data accepted at edge N appears on out_* after edge N when the stage was empty.
REQ-017 States: EMPTY (occ 0), ONE (occ 1), TWO (occ 2, skid only); occupancy SHALL equal the state.
REQ-018 EMPTY->ONE on input transfer; ONE->EMPTY on output transfer with no input transfer; ONE->ONE on simultaneous transfers (new entry replaces head); ONE->TWO on input transfer with out_ready low.
REQ-019 TWO->ONE on output transfer; the skid entry becomes head on the next cycle; in TWO, no input transfer occurs.
REQ-020 When out_valid is low, out_reg_wb, out_mem_we and out_mem_re SHALL be 0 (bubble); data outputs hold their last value.
REQ-021 While out_valid is high and out_ready is low, all out_* SHALL remain stable.
REQ-022 flush SHALL force the next state to EMPTY, overriding any simultaneous input transfer; the output transfer on that same edge still completes.
REQ-023 Payload fields SHALL be stored verbatim, with no arithmetic and no width conversion.

Reset
REQ-024 On reset low: state EMPTY, occupancy 0, out_valid 0, all out_* 0, in_ready 1, asynchronously and independently of clk.
REQ-025 Reset asserted mid-transfer SHALL discard all entries; the first input transfer after release is accepted normally.

Configuration
REQ-026 Macro EX_MEM_SKID_EN.
REQ-027 With EX_MEM_SKID_EN defined: two entries (head plus skid); in_ready is a flop output, high in EMPTY and ONE; full throughput without a combinational path from out_ready to in_ready.
REQ-028 Without EX_MEM_SKID_EN: single entry; TWO does not exist; in_ready = ~out_valid | out_ready (combinational); occupancy[1] is always 0.

Verification
REQ-029 Release reset, stream in_aluA=1..8 with out_ready=1 -> out_aluA=1..8 each one cycle later; occupancy never exceeds 1.
REQ-030 Skid build: accept aluA=5, then aluA=6 with out_ready=0 -> occupancy=2, in_ready=0, out_aluA holds 5; raise out_ready -> 5 then 6 out, no loss.
REQ-031 Non-skid build, same stimulus -> in_ready=0 while out_valid=1 and out_ready=0; 6 accepted only after 5 is consumed.
REQ-032 flush together with in_valid=1, in_reg_wb=1 while holding 2 entries -> next cycle out_valid=0, out_reg_wb=0, out_mem_we=0, occupancy=0.
REQ-033 Assert reset low mid-stream at a non-edge time -> out_valid=0 and all out_* =0 immediately; after release, aluA=0x3FF passes through intact.
REQ-034 Parameters DATA_W=16, ADDR_W=4: in_store_data=0xBEEF, in_rs2_addr=0xA -> identical values on out_*.
